// File: rtl/hazard_unit.sv
// Decode-stage scoreboard: tracks pending register-bank writes per register,
// gates issue on RAW / WAW-overflow / depth limits and drains on control transfers.
//
// state  | meaning
// RUN    | normal issue
// HAZARD | decode instruction held by a hazard, overflow or depth limit
// DRAIN  | control transfer issued; no issue until all writes complete
module hazard_unit #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_MAX      = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       id_valid,
    input  logic [3:0] id_RA,
    input  logic [3:0] id_RB,
    input  logic [3:0] id_WC,
    input  logic       id_use_ra,
    input  logic       id_use_rb,
    input  logic       id_W_RB,
    input  logic       id_ctrl,
    input  logic       wb_valid,
    input  logic [3:0] wb_WC,
    output logic       issue,
    output logic       stall,
    output logic [1:0] state,
    output logic [2:0] inflight,
    output logic       wb_err
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HAZARD = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [1:0] CNT_TOP  = 2'(CNT_MAX);
    localparam logic [2:0] INFL_TOP = 3'(MAX_INFLIGHT);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] cnt_q [16];
    logic [1:0] cnt_d [16];
    logic [2:0] inflight_q;
    logic [2:0] inflight_d;
    logic       wb_err_q;

    logic raw;
    logic ovf;
    logic full;
    logic inc;
    logic wb_ok;
    logic wb_bad;

    // Hazard terms look only at registered counters: a completion this cycle
    // does not unblock the decode instruction until the next cycle.
    always_comb begin
        raw  = (id_use_ra && (cnt_q[id_RA] != 2'd0)) ||
               (id_use_rb && (cnt_q[id_RB] != 2'd0));
        ovf  = id_W_RB && (cnt_q[id_WC] == CNT_TOP);
        full = id_W_RB && (inflight_q == INFL_TOP);
    end

    assign issue  = id_valid && !RESET && (state_q != DRAIN) && !raw && !ovf && !full;
    assign stall  = id_valid && !issue;
    assign inc    = issue && id_W_RB;
    assign wb_ok  = wb_valid && (cnt_q[wb_WC] != 2'd0);
    assign wb_bad = wb_valid && (cnt_q[wb_WC] == 2'd0);

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc && (id_WC == 4'(i)) && !(wb_ok && (wb_WC == 4'(i)))) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (wb_ok && (wb_WC == 4'(i)) && !(inc && (id_WC == 4'(i)))) begin
                cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({inc, wb_ok})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (issue && id_ctrl) begin
                    state_d = DRAIN;
                end else if (stall) begin
                    state_d = HAZARD;
                end
            end
            HAZARD: begin
                if (issue) begin
                    state_d = id_ctrl ? DRAIN : RUN;
                end else if (!id_valid) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (inflight_d == 3'd0) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= RUN;
            inflight_q <= 3'd0;
            wb_err_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            if (wb_bad) begin
                wb_err_q <= 1'b1;
            end
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign state    = state_q;
    assign inflight = inflight_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios followed by random traffic,
// each cycle compared against a scoreboard of pending writes per register.
module tb_hazard_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       id_valid;
    logic [3:0] id_RA;
    logic [3:0] id_RB;
    logic [3:0] id_WC;
    logic       id_use_ra;
    logic       id_use_rb;
    logic       id_W_RB;
    logic       id_ctrl;
    logic       wb_valid;
    logic [3:0] wb_WC;
    logic       issue;
    logic       stall;
    logic [1:0] state;
    logic [2:0] inflight;
    logic       wb_err;

    hazard_unit #(.MAX_INFLIGHT(4), .CNT_MAX(3)) dut (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_RA(id_RA), .id_RB(id_RB),
        .id_WC(id_WC), .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_W_RB(id_W_RB),
        .id_ctrl(id_ctrl), .wb_valid(wb_valid), .wb_WC(wb_WC), .issue(issue),
        .stall(stall), .state(state), .inflight(inflight), .wb_err(wb_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference: pending writes per register, total outstanding, sticky error, mode 0/1/2.
    int cnt_m [16];
    int infl_m;
    int err_m;
    int st_m;
    logic obs_issue;
    logic obs_stall;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] wc, input logic ura, input logic urb,
                        input logic w, input logic ctl, input logic wbv,
                        input logic [3:0] wbwc, input logic rst);
        bit exp_issue;
        bit exp_stall;
        bit wb_hit;
        id_valid = v;  id_RA = ra;  id_RB = rb;  id_WC = wc;
        id_use_ra = ura;  id_use_rb = urb;  id_W_RB = w;  id_ctrl = ctl;
        wb_valid = wbv;  wb_WC = wbwc;  RESET = rst;
        #1;
        exp_issue = v && !rst && (st_m != 2) &&
                    !(ura && cnt_m[ra] > 0) && !(urb && cnt_m[rb] > 0) &&
                    !(w && cnt_m[wc] == 3) && !(w && infl_m == 4);
        exp_stall = v && !exp_issue;
        obs_issue = issue;
        obs_stall = stall;
        check("issue", 8'(issue), 8'(exp_issue));
        check("stall", 8'(stall), 8'(exp_stall));
        check("state", 8'(state), 8'(st_m));
        check("inflight", 8'(inflight), 8'(infl_m));
        check("wb_err", 8'(wb_err), 8'(err_m));
        @(posedge CLK);
        if (rst) begin
            foreach (cnt_m[i]) cnt_m[i] = 0;
            infl_m = 0;
            err_m  = 0;
            st_m   = 0;
        end else begin
            wb_hit = wbv && (cnt_m[wbwc] > 0);
            if (exp_issue && w) begin
                cnt_m[wc]++;
                infl_m++;
            end
            if (wbv) begin
                if (wb_hit) begin
                    cnt_m[wbwc]--;
                    infl_m--;
                end else begin
                    err_m = 1;
                end
            end
            case (st_m)
                0: if (exp_issue && ctl) st_m = 2; else if (exp_stall) st_m = 1;
                1: if (exp_issue) st_m = ctl ? 2 : 0; else if (!v) st_m = 0;
                default: if (infl_m == 0) st_m = 0;
            endcase
        end
        @(negedge CLK);
    endtask

    task automatic wr(input logic [3:0] wc);
        step(1, 0, 0, wc, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [3:0] ra, input logic wbv, input logic [3:0] wbwc);
        step(1, ra, 0, 0, 1, 0, 0, 0, wbv, wbwc, 0);
    endtask

    task automatic ctrl_instr();
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic idle(input logic wbv, input logic [3:0] wbwc);
        step(0, 0, 0, 0, 0, 0, 0, 0, wbv, wbwc, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        int live [$];
        logic v, ura, urb, w, ctl, wbv, rst;
        logic [3:0] ra, rb, wc, wbwc;

        foreach (cnt_m[i]) cnt_m[i] = 0;
        infl_m = 0;
        err_m  = 0;
        st_m   = 0;
        @(negedge CLK);
        do_reset();

        // RAW on r3, completion does not bypass
        wr(3);
        check("s1_issue_w3", 8'(obs_issue), 8'd1);
        rd(3, 0, 0);
        check("s1_stall", 8'(obs_stall), 8'd1);
        check("s1_state_haz", 8'(state), 8'd1);
        rd(3, 1, 3);
        check("s1_stall_wb", 8'(obs_stall), 8'd1);
        rd(3, 0, 0);
        check("s1_issue", 8'(obs_issue), 8'd1);
        check("s1_state_run", 8'(state), 8'd0);

        // depth limit
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            wr(4'(k));
            check("s2_issue", 8'(obs_issue), 8'd1);
        end
        check("s2_inflight", 8'(inflight), 8'd4);
        wr(5);
        check("s2_full", 8'(obs_stall), 8'd1);
        step(1, 0, 0, 5, 0, 0, 1, 0, 1, 1, 0);
        check("s2_full_wb", 8'(obs_stall), 8'd1);
        wr(5);
        check("s2_issue5", 8'(obs_issue), 8'd1);

        // per-register overflow on r7
        do_reset();
        for (int k = 0; k < 3; k++) wr(7);
        wr(7);
        check("s3_ovf", 8'(obs_stall), 8'd1);
        step(1, 0, 0, 7, 0, 0, 1, 0, 1, 7, 0);
        check("s3_ovf_wb", 8'(obs_stall), 8'd1);
        step(1, 0, 0, 7, 0, 0, 1, 0, 1, 7, 0);
        check("s3_same_issue", 8'(obs_issue), 8'd1);
        check("s3_same_infl", 8'(inflight), 8'd2);
        wr(7);
        check("s3_refill", 8'(obs_issue), 8'd1);
        wr(7);
        check("s3_ovf2", 8'(obs_stall), 8'd1);

        // drain after control transfer
        do_reset();
        wr(1);
        wr(2);
        ctrl_instr();
        check("s4_ctrl_issue", 8'(obs_issue), 8'd1);
        check("s4_drain", 8'(state), 8'd2);
        rd(4, 0, 0);
        check("s4_block", 8'(obs_issue), 8'd0);
        rd(4, 1, 1);
        check("s4_block_wb1", 8'(obs_issue), 8'd0);
        rd(4, 1, 2);
        check("s4_block_wb2", 8'(obs_issue), 8'd0);
        check("s4_run", 8'(state), 8'd0);
        check("s4_infl", 8'(inflight), 8'd0);

        // control transfer with nothing outstanding
        ctrl_instr();
        check("s4b_drain", 8'(state), 8'd2);
        idle(0, 0);
        check("s4b_run", 8'(state), 8'd0);

        // stray completion
        idle(1, 9);
        check("s5_err", 8'(wb_err), 8'd1);
        idle(0, 0);
        idle(0, 0);
        check("s5_err_sticky", 8'(wb_err), 8'd1);
        do_reset();
        check("s5_err_clr", 8'(wb_err), 8'd0);
        check("s5_infl_clr", 8'(inflight), 8'd0);
        check("s5_state_clr", 8'(state), 8'd0);

        // reset abandons drain
        wr(1);
        wr(2);
        wr(3);
        ctrl_instr();
        check("s6_drain", 8'(state), 8'd2);
        check("s6_infl3", 8'(inflight), 8'd3);
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        check("s6_rst_issue", 8'(obs_issue), 8'd0);
        check("s6_rst_stall", 8'(obs_stall), 8'd1);
        check("s6_state", 8'(state), 8'd0);
        check("s6_infl", 8'(inflight), 8'd0);
        rd(1, 0, 0);
        check("s6_issue", 8'(obs_issue), 8'd1);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            ra  = 4'($urandom_range(0, 7));
            rb  = 4'($urandom_range(0, 7));
            wc  = 4'($urandom_range(0, 7));
            ura = 1'($urandom_range(0, 1));
            urb = 1'($urandom_range(0, 1));
            w   = ($urandom_range(0, 3) != 0);
            ctl = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            wbv = 1'b0;
            wbwc = 4'd0;
            live.delete();
            for (int r = 0; r < 16; r++) if (cnt_m[r] > 0) live.push_back(r);
            if (live.size() > 0 && $urandom_range(0, 1) == 1) begin
                wbv  = 1'b1;
                wbwc = 4'(live[$urandom_range(0, live.size() - 1)]);
            end else if ($urandom_range(0, 59) == 0) begin
                wbv  = 1'b1;
                wbwc = 4'($urandom_range(0, 15));
            end
            step(v, ra, rb, wc, ura, urb, w, ctl, wbv, wbwc, rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
